floo_serial_link_pwr_seq: RTL and testbench

Power/isolation sequencer for the floo serial link, sitting between the link's configuration registers and the link clock gate, reset mux and isolation handshake. It generalises the fixed clock-enable/reset/isolate wiring of the current wrapper to N channels and adds enforced ordering with timed delays and handshake timeouts. A software-controlled enable brings the link up or down safely. Error recovery is explicit.

---
 rtl/floo_serial_link_pwr_pkg.sv | 48 ++++
 rtl/floo_sl_delay_cnt.sv | 36 +++
 rtl/floo_serial_link_pwr_seq.sv | 133 +++++++++++++
 tb/tb_floo_serial_link_pwr_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/floo_serial_link_pwr_pkg.sv
// Shared types and the state-to-output decode for the serial link power sequencer.
package floo_serial_link_pwr_pkg;

    typedef enum logic [2:0] {
        StOff    = 3'd0,
        StClkOn  = 3'd1,
        StRstRel = 3'd2,
        StDeiso  = 3'd3,
        StUp     = 3'd4,
        StIso    = 3'd5,
        StRstAss = 3'd6,
        StError  = 3'd7
    } pwr_state_e;

    typedef struct packed {
        logic clk_ena;
        logic rst_n;
        logic isolate;
        logic up;
        logic err;
    } pwr_out_t;

    // Pure decode of the registered state; keeps every output free of input paths.
    function automatic pwr_out_t pwr_decode(input pwr_state_e st);
        pwr_out_t o;
        o = '{clk_ena: 1'b1, rst_n: 1'b0, isolate: 1'b1, up: 1'b0, err: 1'b0};
        unique case (st)
            StOff:    o.clk_ena = 1'b0;
            StClkOn:  o.rst_n   = 1'b0;
            StRstRel: o.rst_n   = 1'b1;
            StDeiso: begin
                o.rst_n   = 1'b1;
                o.isolate = 1'b0;
            end
            StUp: begin
                o.rst_n   = 1'b1;
                o.isolate = 1'b0;
                o.up      = 1'b1;
            end
            StIso:    o.rst_n   = 1'b1;
            StRstAss: o.rst_n   = 1'b0;
            StError:  o.err     = 1'b1;
            default:  o.clk_ena = 1'b0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/floo_sl_delay_cnt.sv
// Saturating cycle counter with synchronous clear and terminal-count compare.
module floo_sl_delay_cnt #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [Width-1:0] tc,
    output logic             done
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Clear wins over count; saturate at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == tc);

endmodule

// File: rtl/floo_serial_link_pwr_seq.sv
// Power/isolation sequencer: orders clock enable, reset release and de-isolation of
// the serial link, with timed delays and handshake timeouts.
module floo_serial_link_pwr_seq
    import floo_serial_link_pwr_pkg::*;
#(
    parameter int unsigned NumChannels   = 1,
    parameter int unsigned NumDirs       = 2,
    parameter int unsigned RstCycles     = 8,
    parameter int unsigned SettleCycles  = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   link_en_i,
    input  logic [NumChannels-1:0] chan_en_i,
    input  logic                   err_clr_i,
    input  logic [NumDirs-1:0]     isolated_i,
    output logic [NumDirs-1:0]     isolate_o,
    output logic                   clk_ena_o,
    output logic [NumChannels-1:0] chan_clk_ena_o,
    output logic                   reset_no,
    output logic                   up_o,
    output logic                   err_o,
    output logic [2:0]             state_o
);

    localparam int unsigned MaxA     = (RstCycles > SettleCycles) ? RstCycles : SettleCycles;
    localparam int unsigned MaxCnt   = (MaxA > TimeoutCycles) ? MaxA : TimeoutCycles;
    localparam int unsigned CntWidth = $clog2(MaxCnt + 1);

    localparam logic [CntWidth-1:0] RstTc    = CntWidth'(RstCycles - 1);
    localparam logic [CntWidth-1:0] SettleTc = CntWidth'(SettleCycles - 1);
    localparam logic [CntWidth-1:0] ToTc     =
        (TimeoutCycles == 0) ? '0 : CntWidth'(TimeoutCycles - 1);
    localparam logic TimeoutEn = (TimeoutCycles != 0);

    pwr_state_e             state_q, state_d;
    logic [NumChannels-1:0] mask_q, mask_d;
    logic [CntWidth-1:0]    tc;
    logic                   cnt_done;
    logic                   cnt_clr;
    pwr_out_t               dec;

    // Counter restarts on every state change so each state times itself from zero.
    assign cnt_clr = (state_d != state_q);

    floo_sl_delay_cnt #(
        .Width (CntWidth)
    ) u_delay_cnt (
        .clk  (clk_i),
        .rst  (rst_i),
        .clr  (cnt_clr),
        .en   (1'b1),
        .tc   (tc),
        .done (cnt_done)
    );

    // Next-state, mask capture and per-state terminal count.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        tc      = RstTc;
        unique case (state_q)
            StOff: begin
                if (link_en_i && (|chan_en_i)) begin
                    state_d = StClkOn;
                    mask_d  = chan_en_i;
                end
            end
            StClkOn: begin
                tc = RstTc;
                if (cnt_done) state_d = StRstRel;
            end
            StRstRel: begin
                tc = SettleTc;
                if (cnt_done) state_d = StDeiso;
            end
            StDeiso: begin
                tc = ToTc;
                // Handshake beats a timeout landing in the same cycle.
                if (isolated_i == '0) begin
                    state_d = StUp;
                end else if (TimeoutEn && cnt_done) begin
                    state_d = StError;
                end
            end
            StUp: begin
                if (!link_en_i) state_d = StIso;
            end
            StIso: begin
                tc = ToTc;
                if (&isolated_i) begin
                    state_d = StRstAss;
                end else if (TimeoutEn && cnt_done) begin
                    state_d = StError;
                end
            end
            StRstAss: begin
                tc = RstTc;
                if (cnt_done) state_d = StOff;
            end
            StError: begin
                if (err_clr_i) state_d = StOff;
            end
            default: state_d = StOff;
        endcase
        if ((state_d == StOff) && (state_q != StOff)) begin
            mask_d = '0;
        end
    end

    // State and channel mask registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StOff;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    // Outputs decoded from registered state and mask only.
    assign dec            = pwr_decode(state_q);
    assign clk_ena_o      = dec.clk_ena;
    assign reset_no       = dec.rst_n;
    assign isolate_o      = {NumDirs{dec.isolate}};
    assign up_o           = dec.up;
    assign err_o          = dec.err;
    assign chan_clk_ena_o = {NumChannels{dec.clk_ena}} & mask_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_floo_serial_link_pwr_seq.sv
// Directed, table-driven bench for the serial link power sequencer.
module tb_floo_serial_link_pwr_seq;

    localparam int unsigned NCh = 4;

    localparam logic [2:0] SOff = 3'd0, SClkOn = 3'd1, SRstRel = 3'd2, SDeiso = 3'd3;
    localparam logic [2:0] SUp = 3'd4, SIso = 3'd5, SRstAss = 3'd6, SErr = 3'd7;

    // Expected {clk_ena, reset_no, isolate[1:0], up, err} per state.
    localparam logic [5:0] OOff   = 6'b001100;
    localparam logic [5:0] OClk   = 6'b101100;
    localparam logic [5:0] ORRel  = 6'b111100;
    localparam logic [5:0] ODeiso = 6'b110000;
    localparam logic [5:0] OUp    = 6'b110010;
    localparam logic [5:0] OIso   = 6'b111100;
    localparam logic [5:0] ORAss  = 6'b101100;
    localparam logic [5:0] OErr   = 6'b101101;

    logic           clk = 1'b0;
    logic           rst;
    logic           link_en;
    logic [NCh-1:0] chan_en;
    logic           err_clr;
    logic [1:0]     isolated;
    logic [1:0]     isolate;
    logic           clk_ena;
    logic [NCh-1:0] chan_clk_ena;
    logic           reset_n;
    logic           up;
    logic           err;
    logic [2:0]     state;

    logic           iso_mode;  // 0: link acks immediately, 1: isolated forced to iso_val
    logic [1:0]     iso_val;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign isolated = iso_mode ? iso_val : isolate;

    floo_serial_link_pwr_seq #(
        .NumChannels   (NCh),
        .NumDirs       (2),
        .RstCycles     (8),
        .SettleCycles  (4),
        .TimeoutCycles (16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .link_en_i      (link_en),
        .chan_en_i      (chan_en),
        .err_clr_i      (err_clr),
        .isolated_i     (isolated),
        .isolate_o      (isolate),
        .clk_ena_o      (clk_ena),
        .chan_clk_ena_o (chan_clk_ena),
        .reset_no       (reset_n),
        .up_o           (up),
        .err_o          (err),
        .state_o        (state)
    );

    typedef struct {
        logic           link_en;
        logic [NCh-1:0] chan_en;
        logic           err_clr;
        logic           iso_mode;
        logic [1:0]     iso_val;
        int             n;
        logic [2:0]     st;
        logic [NCh-1:0] chan;
        logic [5:0]     outs;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic le, input logic [NCh-1:0] ce, input logic ec,
                               input logic im, input logic [1:0] iv, input int n,
                               input logic [2:0] st, input logic [NCh-1:0] ch,
                               input logic [5:0] o);
        vec_t r;
        r.link_en = le; r.chan_en = ce; r.err_clr = ec; r.iso_mode = im; r.iso_val = iv;
        r.n = n; r.st = st; r.chan = ch; r.outs = o;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input int idx, input logic [2:0] st,
                           input logic [NCh-1:0] ch, input logic [5:0] o);
        chk({name, "_state"}, idx, 32'(state), 32'(st));
        chk({name, "_outs"}, idx, 32'({clk_ena, reset_n, isolate, up, err}), 32'(o));
        chk({name, "_chan"}, idx, 32'(chan_clk_ena), 32'(ch));
    endtask

    int first_clk, first_rst, first_deiso, first_up;

    initial begin
        rst = 1'b1; link_en = 1'b0; chan_en = '0; err_clr = 1'b0;
        iso_mode = 1'b0; iso_val = 2'b11;
        step(2);
        chk_all("reset", 0, SOff, 4'b0000, OOff);
        rst = 1'b0;

        // Up latency with an immediately acking link.
        link_en = 1'b1; chan_en = 4'b0001;
        first_clk = -1; first_rst = -1; first_deiso = -1; first_up = -1;
        for (int e = 1; e <= 20; e++) begin
            step(1);
            if (first_clk < 0 && clk_ena) first_clk = e;
            if (first_rst < 0 && reset_n) first_rst = e;
            if (first_deiso < 0 && clk_ena && isolate == 2'b00) first_deiso = e;
            if (first_up < 0 && up) first_up = e;
        end
        chk("lat_clk_ena", 0, 32'(first_clk), 32'd1);
        chk("lat_reset_n", 0, 32'(first_rst), 32'd9);
        chk("lat_deiso", 0, 32'(first_deiso), 32'd13);
        chk("lat_up", 0, 32'(first_up), 32'd14);
        link_en = 1'b0;
        step(9);
        chk_all("down_m1", 0, SRstAss, 4'b0001, ORAss);
        step(1);
        chk_all("down", 0, SOff, 4'b0000, OOff);

        // Reset mid-sequence while in RST_REL, then restart with link_en still high.
        link_en = 1'b1; chan_en = 4'b0101;
        step(10);
        chk_all("pre_rst", 0, SRstRel, 4'b0101, ORRel);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_all("mid_rst", 0, SOff, 4'b0000, OOff);
        step(1);
        chk_all("restart", 0, SClkOn, 4'b0101, OClk);
        link_en = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;

        //              le    chan     ec    im    iv     n   state    chan     outs
        vecs.push_back(v(1'b0, 4'b0101, 1'b0, 1'b0, 2'b00, 3,  SOff,    4'b0000, OOff));
        vecs.push_back(v(1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 5,  SOff,    4'b0000, OOff));
        vecs.push_back(v(1'b1, 4'b0101, 1'b0, 1'b0, 2'b00, 1,  SClkOn,  4'b0101, OClk));
        vecs.push_back(v(1'b1, 4'b1111, 1'b0, 1'b0, 2'b00, 7,  SClkOn,  4'b0101, OClk));
        vecs.push_back(v(1'b1, 4'b1111, 1'b0, 1'b0, 2'b00, 1,  SRstRel, 4'b0101, ORRel));
        vecs.push_back(v(1'b1, 4'b1111, 1'b0, 1'b0, 2'b00, 3,  SRstRel, 4'b0101, ORRel));
        vecs.push_back(v(1'b1, 4'b1111, 1'b0, 1'b0, 2'b00, 1,  SDeiso,  4'b0101, ODeiso));
        vecs.push_back(v(1'b1, 4'b1111, 1'b0, 1'b0, 2'b00, 1,  SUp,     4'b0101, OUp));
        vecs.push_back(v(1'b1, 4'b1111, 1'b0, 1'b0, 2'b00, 4,  SUp,     4'b0101, OUp));
        vecs.push_back(v(1'b0, 4'b1111, 1'b0, 1'b1, 2'b00, 1,  SIso,    4'b0101, OIso));
        vecs.push_back(v(1'b0, 4'b1111, 1'b0, 1'b1, 2'b01, 4,  SIso,    4'b0101, OIso));
        vecs.push_back(v(1'b0, 4'b1111, 1'b0, 1'b1, 2'b11, 1,  SRstAss, 4'b0101, ORAss));
        vecs.push_back(v(1'b0, 4'b1111, 1'b0, 1'b1, 2'b11, 7,  SRstAss, 4'b0101, ORAss));
        vecs.push_back(v(1'b0, 4'b1111, 1'b0, 1'b1, 2'b11, 1,  SOff,    4'b0000, OOff));
        // DEISO handshake stuck: timeout after 16 cycles.
        vecs.push_back(v(1'b1, 4'b0011, 1'b0, 1'b1, 2'b11, 13, SDeiso,  4'b0011, ODeiso));
        vecs.push_back(v(1'b1, 4'b0011, 1'b0, 1'b1, 2'b11, 15, SDeiso,  4'b0011, ODeiso));
        vecs.push_back(v(1'b1, 4'b0011, 1'b0, 1'b1, 2'b11, 1,  SErr,    4'b0011, OErr));
        vecs.push_back(v(1'b0, 4'b0011, 1'b0, 1'b1, 2'b11, 3,  SErr,    4'b0011, OErr));
        vecs.push_back(v(1'b0, 4'b0011, 1'b1, 1'b1, 2'b11, 1,  SOff,    4'b0000, OOff));
        vecs.push_back(v(1'b0, 4'b0011, 1'b0, 1'b1, 2'b11, 2,  SOff,    4'b0000, OOff));
        // ISO ack arriving on the timeout cycle wins.
        vecs.push_back(v(1'b1, 4'b1000, 1'b0, 1'b0, 2'b00, 14, SUp,     4'b1000, OUp));
        vecs.push_back(v(1'b0, 4'b1000, 1'b0, 1'b1, 2'b00, 16, SIso,    4'b1000, OIso));
        vecs.push_back(v(1'b0, 4'b1000, 1'b0, 1'b1, 2'b11, 1,  SRstAss, 4'b1000, ORAss));
        vecs.push_back(v(1'b0, 4'b1000, 1'b0, 1'b1, 2'b11, 8,  SOff,    4'b0000, OOff));
        // link_en toggled during the up-sequence: full up, then full down.
        vecs.push_back(v(1'b1, 4'b0001, 1'b0, 1'b0, 2'b00, 2,  SClkOn,  4'b0001, OClk));
        vecs.push_back(v(1'b0, 4'b0001, 1'b0, 1'b0, 2'b00, 11, SDeiso,  4'b0001, ODeiso));
        vecs.push_back(v(1'b0, 4'b0001, 1'b0, 1'b0, 2'b00, 1,  SUp,     4'b0001, OUp));
        vecs.push_back(v(1'b0, 4'b0001, 1'b0, 1'b0, 2'b00, 1,  SIso,    4'b0001, OIso));
        vecs.push_back(v(1'b0, 4'b0001, 1'b0, 1'b0, 2'b00, 1,  SRstAss, 4'b0001, ORAss));
        vecs.push_back(v(1'b0, 4'b0001, 1'b0, 1'b0, 2'b00, 8,  SOff,    4'b0000, OOff));

        for (int i = 0; i < vecs.size(); i++) begin
            link_en  = vecs[i].link_en;
            chan_en  = vecs[i].chan_en;
            err_clr  = vecs[i].err_clr;
            iso_mode = vecs[i].iso_mode;
            iso_val  = vecs[i].iso_val;
            step(vecs[i].n);
            chk_all("vec", i, vecs[i].st, vecs[i].chan, vecs[i].outs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
